// File: rtl/observer_accel_seq.sv
// observer_accel_seq: configures the accelerometer on the observer SPI bus,
// then reads X/Y/Z periodically (or on i_trig) and publishes 48-bit records.
// Optional identity check before configuration: OBSERVER_ACCEL_WHOAMI_EN.
//
// state   | meaning
// ST_ID   | send 0x8F,0x00 and compare the identity byte (macro only)
// ST_CFG  | write CTRL1_VAL to register 0x20
// ST_WAIT | period down-counter running; i_trig starts a read early
// ST_READ | burst-read 0x28..0x2D into the shadow register
// ST_ERR  | identity mismatch, bus silent until reset
module observer_accel_seq #(
  parameter int unsigned PERIOD     = 500000,
  parameter logic [7:0]  CTRL1_VAL  = 8'h57,
  parameter logic [7:0]  WHOAMI_VAL = 8'h33
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_trig,
  output logic [7:0]  o_spi_data,
  output logic        o_spi_valid,
  output logic        o_spi_last,
  input  logic        i_spi_ready,
  input  logic [7:0]  i_spi_rdata,
  input  logic        i_spi_rvalid,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic [15:0] o_z,
  output logic        o_sample_valid,
  input  logic        i_sample_ready,
  output logic        o_busy,
  output logic        o_err,
  output logic [7:0]  o_overrun
);

  localparam int TW = $clog2(PERIOD);

  typedef enum logic [2:0] {
`ifdef OBSERVER_ACCEL_WHOAMI_EN
    ST_ID,
`endif
    ST_CFG,
    ST_WAIT,
    ST_READ,
    ST_ERR
  } state_t;

`ifdef OBSERVER_ACCEL_WHOAMI_EN
  localparam state_t ST_RESET = ST_ID;
`else
  localparam state_t ST_RESET = ST_CFG;
`endif

  state_t         state, state_nxt;
  logic [2:0]     tx_cnt, tx_cnt_nxt;
  logic [2:0]     rx_cnt, rx_cnt_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic           spi_valid_nxt;
  logic           spi_last_nxt;
  logic [7:0]     spi_data_nxt;
  logic           busy_nxt;
  logic           publish;
  logic [39:0]    shadow;

  // Number of bytes each transaction transmits.
  function automatic logic [2:0] tx_len(input state_t s);
    case (s)
`ifdef OBSERVER_ACCEL_WHOAMI_EN
      ST_ID:   tx_len = 3'd2;
`endif
      ST_CFG:  tx_len = 3'd2;
      ST_READ: tx_len = 3'd7;
      default: tx_len = 3'd0;
    endcase
  endfunction

  // Byte to transmit at position idx of the transaction owned by state s.
  function automatic logic [7:0] tx_byte(input state_t s, input logic [2:0] idx);
    tx_byte = 8'h00;
    case (s)
`ifdef OBSERVER_ACCEL_WHOAMI_EN
      ST_ID:   tx_byte = (idx == 3'd0) ? 8'h8F : 8'h00;
`endif
      ST_CFG:  tx_byte = (idx == 3'd0) ? 8'h20 : CTRL1_VAL;
      ST_READ: tx_byte = (idx == 3'd0) ? 8'hE8 : 8'h00;
      default: tx_byte = 8'h00;
    endcase
  endfunction

  // Next state, byte/receive counters, period timer and the next SPI byte.
  always_comb begin
    state_nxt  = state;
    tx_cnt_nxt = tx_cnt;
    rx_cnt_nxt = rx_cnt;
    timer_nxt  = timer;
    publish    = 1'b0;

    if (o_spi_valid && i_spi_ready)
      tx_cnt_nxt = tx_cnt + 3'd1;
    // Receive progress follows rvalid only, not transmit progress.
    if (i_spi_rvalid && (tx_len(state) != 3'd0))
      rx_cnt_nxt = rx_cnt + 3'd1;

    case (state)
`ifdef OBSERVER_ACCEL_WHOAMI_EN
      ST_ID: begin
        if (i_spi_rvalid && rx_cnt == 3'd1)
          state_nxt = (i_spi_rdata == WHOAMI_VAL) ? ST_CFG : ST_ERR;
      end
`endif
      ST_CFG: begin
        if (i_spi_rvalid && rx_cnt == 3'd1)
          state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer == '0 || i_trig)
          state_nxt = ST_READ;
        else
          timer_nxt = timer - 1'b1;
      end
      ST_READ: begin
        if (i_spi_rvalid && rx_cnt == 3'd6) begin
          publish   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = state;
    endcase

    // Every state change starts a fresh transaction and reloads the timer;
    // the reload only matters on entry to ST_WAIT.
    if (state_nxt != state) begin
      tx_cnt_nxt = 3'd0;
      rx_cnt_nxt = 3'd0;
      timer_nxt  = TW'(PERIOD - 1);
    end

    spi_valid_nxt = (tx_cnt_nxt < tx_len(state_nxt));
    spi_data_nxt  = spi_valid_nxt ? tx_byte(state_nxt, tx_cnt_nxt) : 8'h00;
    spi_last_nxt  = spi_valid_nxt && (tx_cnt_nxt == tx_len(state_nxt) - 3'd1);
    // Busy from the first presented byte until the transaction's last rvalid.
    busy_nxt      = (tx_len(state_nxt) != 3'd0) && (o_busy || spi_valid_nxt);
  end

  // Sequencer state, counters and registered SPI outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_RESET;
      tx_cnt      <= 3'd0;
      rx_cnt      <= 3'd0;
      timer       <= '0;
      o_spi_valid <= 1'b0;
      o_spi_data  <= 8'h00;
      o_spi_last  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_cnt      <= tx_cnt_nxt;
      rx_cnt      <= rx_cnt_nxt;
      timer       <= timer_nxt;
      o_spi_valid <= spi_valid_nxt;
      o_spi_data  <= spi_data_nxt;
      o_spi_last  <= spi_last_nxt;
      o_busy      <= busy_nxt;
    end
  end

  // Shadow capture of XL..ZL; ZH comes straight from the bus at publish.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      shadow <= '0;
    else if (state == ST_READ && i_spi_rvalid && rx_cnt != 3'd0 && rx_cnt != 3'd6)
      shadow <= {i_spi_rdata, shadow[39:8]};
  end

  // Sample record handshake and saturating overrun counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x            <= 16'h0000;
      o_y            <= 16'h0000;
      o_z            <= 16'h0000;
      o_sample_valid <= 1'b0;
      o_overrun      <= 8'h00;
    end else if (publish) begin
      o_x            <= shadow[15:0];
      o_y            <= shadow[31:16];
      o_z            <= {i_spi_rdata, shadow[39:32]};
      o_sample_valid <= 1'b1;
      if (o_sample_valid && !i_sample_ready && o_overrun != 8'hFF)
        o_overrun <= o_overrun + 8'd1;
    end else if (o_sample_valid && i_sample_ready) begin
      o_sample_valid <= 1'b0;
    end
  end

`ifdef OBSERVER_ACCEL_WHOAMI_EN
  // Identity mismatch flag, held until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_err <= 1'b0;
    else if (state_nxt == ST_ERR)
      o_err <= 1'b1;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_observer_accel_seq.sv
// Bench for observer_accel_seq: SPI slave model with a byte scoreboard,
// table of read vectors, and hand-written overrun/trigger/reset sequences.
module tb_observer_accel_seq;

  localparam int unsigned PERIOD = 20;
  localparam logic [7:0]  CTRL1  = 8'h57;
  localparam logic [7:0]  WHOAMI = 8'h33;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [7:0]  spi_data;
  logic        spi_valid;
  logic        spi_last;
  logic        spi_ready;
  logic [7:0]  spi_rdata;
  logic        spi_rvalid;
  logic [15:0] x, y, z;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        err;
  logic [7:0]  overrun;

  observer_accel_seq #(.PERIOD(PERIOD), .CTRL1_VAL(CTRL1), .WHOAMI_VAL(WHOAMI)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig),
    .o_spi_data(spi_data), .o_spi_valid(spi_valid), .o_spi_last(spi_last),
    .i_spi_ready(spi_ready), .i_spi_rdata(spi_rdata), .i_spi_rvalid(spi_rvalid),
    .o_x(x), .o_y(y), .o_z(z),
    .o_sample_valid(sample_valid), .i_sample_ready(sample_ready),
    .o_busy(busy), .o_err(err), .o_overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  rsp_q[$];
  logic [47:0] smp_q[$];
  int          read_pos = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic push_read_expect();
    exp_q.push_back({8'hE8, 1'b0});
    for (int i = 1; i < 7; i++) exp_q.push_back({8'h00, i == 6});
  endtask

  task automatic push_cfg_expect();
`ifdef OBSERVER_ACCEL_WHOAMI_EN
    exp_q.push_back({8'h8F, 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    rsp_q.push_back(8'h00);
    rsp_q.push_back(WHOAMI);
`endif
    exp_q.push_back({8'h20, 1'b0});
    exp_q.push_back({CTRL1, 1'b1});
    rsp_q.push_back(8'hAA);
    rsp_q.push_back(8'hAA);
  endtask

  task automatic push_read(input vec_t v);
    push_read_expect();
    rsp_q.push_back(8'hFF);
    rsp_q.push_back(v.x[7:0]); rsp_q.push_back(v.x[15:8]);
    rsp_q.push_back(v.y[7:0]); rsp_q.push_back(v.y[15:8]);
    rsp_q.push_back(v.z[7:0]); rsp_q.push_back(v.z[15:8]);
    smp_q.push_back({v.x, v.y, v.z});
  endtask

  // SPI slave: checks each accepted byte against the scoreboard and returns
  // one response byte per accepted byte, one cycle after acceptance.
  initial begin : spi_model
    logic       hs_d;
    logic [7:0] rd_d;
    logic [8:0] e;
    hs_d = 1'b0;
    rd_d = 8'h00;
    spi_rvalid = 1'b0;
    spi_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spi_rvalid = 1'b0;
        hs_d       = 1'b0;
        read_pos   = 0;
      end else begin
        spi_rvalid = hs_d;
        spi_rdata  = rd_d;
        hs_d       = 1'b0;
        if (spi_valid && spi_ready) begin
          if (exp_q.size() == 0) push_read_expect();
          e = exp_q.pop_front();
          chk("spi_byte", {55'd0, spi_data, spi_last}, {55'd0, e});
          hs_d     = 1'b1;
          rd_d     = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
          read_pos = spi_last ? 0 : read_pos + 1;
        end
      end
    end
  end

  // Returns at the first negedge with busy low after a busy period.
  task automatic wait_txn(input string name);
    int n;
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    if (!busy) begin timeout(name); return; end
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) timeout(name);
  endtask

  task automatic measure_period(input string name);
    int n;
    n = 0;
    while (!spi_valid && n < 3 * PERIOD) begin @(negedge clk); n++; end
    chk(name, n, PERIOD);
  endtask

  task automatic check_sample(input string name);
    logic [47:0] e;
    chk({name, "_valid"}, sample_valid, 1'b1);
    if (smp_q.size() == 0) begin timeout({name, "_queue"}); return; end
    e = smp_q.pop_front();
    chk({name, "_x"}, x, e[47:32]);
    chk({name, "_y"}, y, e[31:16]);
    chk({name, "_z"}, z, e[15:0]);
  endtask

  task automatic consume();
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    chk("consume_valid", sample_valid, 1'b0);
  endtask

  task automatic trig_read(input vec_t v, input int delay, input string name);
    repeat (delay) @(negedge clk);
    push_read(v);
    chk({name, "_idle"}, spi_valid, 1'b0);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk({name, "_trig_latency"}, spi_valid, 1'b1);
    wait_txn(name);
    check_sample(name);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_spi"}, {spi_valid, spi_last, spi_data}, 10'd0);
    chk({name, "_busy_err"}, {busy, err}, 2'd0);
    chk({name, "_sample"}, {sample_valid, x, y, z}, 49'd0);
    chk({name, "_overrun"}, overrun, 8'd0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{x: 16'h8000, y: 16'h7FFF, z: 16'hFFFF};
    vecs[1] = '{x: 16'h1234, y: 16'hABCD, z: 16'h0000};
    vecs[2] = '{x: 16'h00FF, y: 16'hFF00, z: 16'h5AA5};
    vecs[3] = '{x: 16'hFFFE, y: 16'h0001, z: 16'h8001};

    rst_n = 1'b1; trig = 1'b0; spi_ready = 1'b1; sample_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

`ifdef OBSERVER_ACCEL_WHOAMI_EN
    exp_q.push_back({8'h8F, 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h32);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("id_mismatch_err", err, 1'b1);
    chk("id_mismatch_silent", {spi_valid, busy}, 2'd0);
    chk("id_mismatch_bytes", exp_q.size(), 0);
    rst_n = 1'b0;
    #1 chk("id_reset_err", err, 1'b0);
    repeat (2) @(negedge clk);
`endif

    // Configuration, then the first periodic read with responses 00..06.
    push_cfg_expect();
    rst_n = 1'b1;
    wait_txn("cfg");
    chk("cfg_bytes_done", exp_q.size(), 0);
    chk("cfg_err", err, 1'b0);
    push_read('{x: 16'h0201, y: 16'h0403, z: 16'h0605});
    measure_period("period_after_cfg");
    wait_txn("first_read");
    check_sample("first_read");
    repeat (3) @(negedge clk);
    chk("hold_until_ready", sample_valid, 1'b1);
    consume();

    for (int i = 0; i < 4; i++) begin
      trig_read(vecs[i], 0, "vec");
      chk("vec_overrun", overrun, 8'd0);
      consume();
    end

    // Two reads without consumption: one overrun, newest record visible.
    trig_read(vecs[0], 0, "ovr_a");
    trig_read(vecs[1], 1, "ovr_b");
    chk("overrun_one", overrun, 8'd1);

    // Periodic reads with no consumer until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      wait_txn("ovr_sat");
      if (i == 99) chk("overrun_101", overrun, 8'd101);
    end
    chk("overrun_sat", overrun, 8'd255);
    chk("ovr_sat_x", x, 16'h0000);
    consume();
    chk("overrun_kept", overrun, 8'd255);

    // Trigger ten cycles into WAIT; a trigger during READ is ignored and
    // the next periodic read follows PERIOD cycles after completion.
    trig_read(vecs[2], 0, "sync");
    consume();
    repeat (8) @(negedge clk);
    push_read(vecs[3]);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("trig10_latency", spi_valid, 1'b1);
    repeat (3) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_txn("trig10");
    check_sample("trig10");
    measure_period("period_after_trig");
    wait_txn("periodic_after_trig");

    // Reset while the fourth read byte is on the bus.
    push_read_expect();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    begin : find_fourth
      for (int n = 0; n < 50; n++) begin
        #1;
        if (read_pos == 4 && spi_valid) disable find_fourth;
        @(negedge clk);
      end
      timeout("fourth_byte");
    end
    rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    rsp_q.delete();
    smp_q.delete();
    push_cfg_expect();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_txn("restart_cfg");
    chk("restart_bytes_done", exp_q.size(), 0);
    measure_period("period_after_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/observer_accel_seq.md
# observer_accel_seq

Transaction sequencer for the accelerometer on the observer SPI bus. It sits between the byte-level SPI master and the sample consumer (UART reporter). After reset it configures the sensor, then reads the X/Y/Z output registers periodically or on a trigger. It presents each sample as one 48-bit record with a valid/ready handshake.

## Interface
Parameters:
- PERIOD, 500000: clock cycles between periodic reads (≥ 16)
- CTRL1_VAL, 8'h57: value written to sensor register 0x20
- WHOAMI_VAL, 8'h33: expected identity byte (used only with the ID-check macro)

Ports:
- i_clk  in  1  system clock (wb_clk domain)
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_trig  in  1  single-cycle request for an immediate read
- o_spi_data  out  8  byte to transmit
- o_spi_valid  out  1  o_spi_data valid
- o_spi_last  out  1  release chip select after this byte
- i_spi_ready  in  1  byte accepted when o_spi_valid & i_spi_ready
- i_spi_rdata  in  8  byte received, one per transmitted byte, in order
- i_spi_rvalid  in  1  i_spi_rdata valid for one cycle
- o_x, o_y, o_z  out  16 each  signed two's-complement sample, little-endian assembled
- o_sample_valid  out  1  sample record valid
- i_sample_ready  in  1  consumer accepts record
- o_busy  out  1  SPI transaction in progress
- o_err  out  1  identity mismatch, sticky until reset
- o_overrun  out  8  count of unconsumed samples overwritten, saturates at 255

## Operation
- States: ID (macro only), CFG, WAIT, READ, ERR.
- Reset state: ID if the macro is defined, else CFG.
- All outputs reset to 0.
- CFG:
  - Sends 0x20 then CTRL1_VAL; o_spi_last is set on the second byte.
  - Goes to WAIT after two i_spi_rvalid pulses.
  - Received data is discarded.
- WAIT:
  - A down-counter is loaded with PERIOD-1 on entry.
  - Goes to READ when the counter reaches 0 or i_trig=1; simultaneous events count as one read.
  - i_trig in any other state is ignored.
- READ:
  - Sends 0xE8 (read, auto-increment, address 0x28), then six 0x00 bytes; o_spi_last is set on the seventh byte.
  - The first rvalid is discarded; the next six are XL, XH, YL, YH, ZL, ZH into a shadow register.
  - On the seventh rvalid the shadow register is copied to o_x/o_y/o_z and o_sample_valid is set.
  - The state then returns to WAIT, which reloads the counter.
- Overrun: if o_sample_valid=1 and i_sample_ready=0 in the cycle a new sample is published, o_overrun increments, saturating at 255, and the old record is overwritten.
- Consume: o_sample_valid clears on a cycle with o_sample_valid & i_sample_ready and no new publish.
  - If a publish coincides with acceptance, the new record is loaded, valid stays 1 and there is no overrun.
- o_busy=1 in CFG, ID and READ from the first o_spi_valid until the last expected rvalid.
- Received-byte counting is by i_spi_rvalid only, independent of transmit progress.

## Timing
- o_spi_valid and o_spi_data hold stable until the handshake.
- The next byte is presented no earlier than the cycle after the handshake.
- Publish latency: o_x/o_y/o_z and o_sample_valid update on the clock edge that samples the seventh (final) rvalid.
- Period: read starts are PERIOD cycles + transaction length apart. The counter is not running during READ.
- i_trig latency: o_spi_valid rises on the first clock edge after the WAIT-state cycle in which i_trig=1.
- Reset mid-transaction: all outputs return to 0 immediately.
  - After release, the sequence restarts from the reset state; the partial transaction is abandoned.
  - Any byte already handed to the SPI master is the master's responsibility.

## Configuration
- OBSERVER_ACCEL_WHOAMI_EN defined:
  - The ID state runs first, sending 0x8F then 0x00 (last).
  - The second rvalid byte is compared with WHOAMI_VAL.
  - Match goes to CFG.
  - Mismatch goes to ERR: o_err=1, o_spi_valid held at 0, no further traffic until reset.
- Macro undefined: no ID state, o_err tied 0, and the first SPI byte after reset is 0x20.

## Test plan
- Reset release with an always-ready SPI model: the bench checks the byte sequence 0x20, CTRL1_VAL with last on the second byte, then 0xE8 plus six 0x00 after PERIOD cycles, last on the seventh.
- Read responses 00 01 02 03 04 05 06: o_x=0x0201, o_y=0x0403, o_z=0x0605, o_sample_valid=1 until i_sample_ready.
- Two reads with i_sample_ready=0: o_overrun=1 and the second record is visible; 300 reads without ready saturate o_overrun at 255.
- i_trig pulse 10 cycles into WAIT: read starts next cycle; the next periodic read is PERIOD cycles after that read completes.
- i_rst_n asserted during the fourth READ byte: outputs go to 0 at once, and the sequence restarts with 0x20 after release.
- Macro defined with identity reply 0x32: o_err=1 and no CFG bytes are sent. With reply 0x33, CFG proceeds normally.
